// File: rtl/fetch_pkg.sv
// rtl/fetch_pkg.sv - shared types and constants for the instruction fetch stage
package fetch_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    DRAIN = 2'd2
  } fetch_state_e;

  localparam logic [31:0] NOP_WORD             = 32'h0000_0000;
  localparam logic [31:0] DEFAULT_RESET_VECTOR = 32'h0000_18C0;

endpackage

// File: rtl/fetch_fifo.sv
// rtl/fetch_fifo.sv - DEPTH-entry synchronous FIFO holding {instruction, address} pairs
module fetch_fifo #(
  parameter int DEPTH = 2,
  parameter int WIDTH = 64,
  localparam int PTR_W = $clog2(DEPTH),
  localparam int CNT_W = $clog2(DEPTH) + 1
) (
  input  logic             clock,
  input  logic             resetN,
  input  logic             push,
  input  logic             pop,
  input  logic             clear,
  input  logic [WIDTH-1:0] wdata,
  output logic [WIDTH-1:0] rdata,
  output logic [CNT_W-1:0] count,
  output logic             empty,
  output logic             full
);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, rd_ptr_q;
  logic [CNT_W-1:0] count_q;
  logic             do_push, do_pop;

  assign empty   = (count_q == '0);
  assign full    = (count_q == CNT_W'(DEPTH));
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);
  assign count   = count_q;
  // Empty FIFO presents zeros so the head is defined out of reset
  assign rdata   = empty ? '0 : mem_q[rd_ptr_q];

  always_ff @(posedge clock or negedge resetN) begin
    if (!resetN) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else if (clear) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
      if (do_pop)  rd_ptr_q <= rd_ptr_q + PTR_W'(1);
      count_q <= count_q + CNT_W'(do_push) - CNT_W'(do_pop);
    end
  end

  always_ff @(posedge clock) begin
    if (do_push && !clear) mem_q[wr_ptr_q] <= wdata;
  end

endmodule

// File: rtl/fetch_stage.sv
// rtl/fetch_stage.sv - single-outstanding instruction fetch FSM with decode FIFO
// Optional wait-timeout and sticky fault enabled by FETCH_TIMEOUT_EN.
module fetch_stage
  import fetch_pkg::*;
#(
  parameter logic [31:0] RESET_VECTOR = DEFAULT_RESET_VECTOR,
  parameter int          FIFO_DEPTH   = 2,
  parameter int          MAX_WAIT     = 15
) (
  input  logic        clock,
  input  logic        resetN,
  input  logic [31:0] pcAddress,
  input  logic        flush,
  input  logic        stall,
  output logic        imemReq,
  output logic [31:0] imemAddr,
  input  logic        imemReady,
  input  logic [31:0] imemData,
  output logic [31:0] instruction,
  output logic [31:0] instrAddress,
  output logic        instrValid,
  output logic        pcHold,
  output logic        fetchFault
);

  localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;

  if ((FIFO_DEPTH < 2) || ((FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0) || (MAX_WAIT < 1)) begin : g_cfg_check
    $error("fetch_stage: FIFO_DEPTH must be a power of two >= 2 and MAX_WAIT >= 1");
  end

  fetch_state_e     state_q, state_d;
  logic [31:0]      addr_q, addr_d;
  logic             push, fetch_done, timeout_hit;
  logic             fifo_pop, fifo_empty, fifo_full;
  logic [CNT_W-1:0] fifo_count;
  logic [63:0]      push_data, head;

  always_comb begin
    state_d    = state_q;
    addr_d     = addr_q;
    imemReq    = 1'b0;
    push       = 1'b0;
    fetch_done = 1'b0;
    case (state_q)
      IDLE: begin
        if ((fifo_count < CNT_W'(FIFO_DEPTH)) && !flush) begin
          addr_d  = pcAddress;
          state_d = FETCH;
        end
      end
      FETCH: begin
        imemReq = 1'b1;
        if (imemReady) begin
          state_d = IDLE;
          if (!flush) begin
            push       = 1'b1;
            fetch_done = 1'b1;
          end
        end else if (flush) begin
          state_d = DRAIN;
        end else if (timeout_hit) begin
          imemReq    = 1'b0;
          push       = 1'b1;
          fetch_done = 1'b1;
          state_d    = IDLE;
        end
      end
      DRAIN: begin
        // Memory still owes a response to the abandoned address; swallow it
        imemReq = 1'b1;
        if (imemReady || timeout_hit) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge resetN) begin
    if (!resetN) begin
      state_q <= IDLE;
      addr_q  <= RESET_VECTOR;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
    end
  end

`ifdef FETCH_TIMEOUT_EN
  localparam int WAIT_W = $clog2(MAX_WAIT + 1);

  logic [WAIT_W-1:0] wait_q, wait_d;
  logic              fault_q, fault_d;

  assign timeout_hit = (state_q != IDLE) && (wait_q == WAIT_W'(MAX_WAIT));

  always_comb begin
    wait_d  = wait_q;
    fault_d = fault_q;
    if ((state_q == IDLE) || (state_d != state_q)) wait_d = '0;
    else if (!timeout_hit)                         wait_d = wait_q + WAIT_W'(1);
    if (flush) fault_d = 1'b0;
    else if ((state_q == FETCH) && timeout_hit && !imemReady) fault_d = 1'b1;
  end

  always_ff @(posedge clock or negedge resetN) begin
    if (!resetN) begin
      wait_q  <= '0;
      fault_q <= 1'b0;
    end else begin
      wait_q  <= wait_d;
      fault_q <= fault_d;
    end
  end

  assign fetchFault = fault_q;
`else
  assign timeout_hit = 1'b0;
  assign fetchFault  = 1'b0;
`endif

  assign push_data = {(imemReady ? imemData : NOP_WORD), addr_q};
  assign fifo_pop  = !fifo_empty && !stall;

  fetch_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (64)
  ) u_fifo (
    .clock  (clock),
    .resetN (resetN),
    .push   (push),
    .pop    (fifo_pop),
    .clear  (flush),
    .wdata  (push_data),
    .rdata  (head),
    .count  (fifo_count),
    .empty  (fifo_empty),
    .full   (fifo_full)
  );

  assert property (@(posedge clock) disable iff (!resetN) !(push && fifo_full && !fifo_pop));

  assign imemAddr     = addr_q;
  assign instruction  = head[63:32];
  assign instrAddress = head[31:0];
  assign instrValid   = !fifo_empty;
  assign pcHold       = !fetch_done;

endmodule

// File: tb/tb_fetch_stage.sv
// tb/tb_fetch_stage.sv - directed and randomized bench for fetch_stage against a queue model
module tb_fetch_stage;

  localparam int          DEPTH = 2;
  localparam int          MAXW  = 15;
  localparam logic [31:0] RV    = 32'h18C0;

  logic        clock = 1'b0;
  logic        resetN = 1'b0;
  logic [31:0] pcAddress = RV;
  logic        flush = 1'b0;
  logic        stall = 1'b0;
  logic        imemReady = 1'b0;
  logic [31:0] imemData = 32'h0;
  logic        imemReq;
  logic [31:0] imemAddr;
  logic [31:0] instruction;
  logic [31:0] instrAddress;
  logic        instrValid;
  logic        pcHold;
  logic        fetchFault;

  fetch_stage #(
    .RESET_VECTOR (RV),
    .FIFO_DEPTH   (DEPTH),
    .MAX_WAIT     (MAXW)
  ) dut (
    .clock        (clock),
    .resetN       (resetN),
    .pcAddress    (pcAddress),
    .flush        (flush),
    .stall        (stall),
    .imemReq      (imemReq),
    .imemAddr     (imemAddr),
    .imemReady    (imemReady),
    .imemData     (imemData),
    .instruction  (instruction),
    .instrAddress (instrAddress),
    .instrValid   (instrValid),
    .pcHold       (pcHold),
    .fetchFault   (fetchFault)
  );

  always #5 clock = ~clock;

  int n_cmp = 0;
  int n_err = 0;

  // Reference: 0 = no request, 1 = request pending, 2 = discarding a flushed request
  int          m_st;
  logic [31:0] m_addr;
  logic [63:0] m_q[$];
  int          m_wait;
  bit          m_fault;
  logic [31:0] pc;
  logic [31:0] redirect;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_st    = 0;
    m_addr  = RV;
    m_q.delete();
    m_wait  = 0;
    m_fault = 0;
    pc      = RV;
  endtask

  task automatic step(input bit rst, input bit rdy, input logic [31:0] data, input bit fl, input bit st);
    bit          tmo, done, req;
    int          nst;
    logic [31:0] exp_i, exp_a;
    @(negedge clock);
    if (rst) model_reset();
    resetN    = !rst;
    imemReady = rdy;
    imemData  = data;
    flush     = fl;
    stall     = st;
    pcAddress = pc;
    #1;
    tmo = 1'b0;
`ifdef FETCH_TIMEOUT_EN
    tmo = (m_st == 1) && (m_wait == MAXW) && !rdy && !fl && !rst;
`endif
    done  = !rst && (((m_st == 1) && rdy && !fl) || tmo);
    req   = (m_st == 2) || ((m_st == 1) && !tmo);
    exp_i = (m_q.size() != 0) ? m_q[0][63:32] : 32'h0;
    exp_a = (m_q.size() != 0) ? m_q[0][31:0]  : 32'h0;
    check("imemReq", imemReq, req);
    check("imemAddr", imemAddr, m_addr);
    check("pcHold", pcHold, !done);
    check("instrValid", instrValid, m_q.size() != 0);
    check("instruction", instruction, exp_i);
    check("instrAddress", instrAddress, exp_a);
    check("fetchFault", fetchFault, m_fault);
    if (rst) return;

    nst = m_st;
    if (m_st == 0) begin
      if (m_q.size() < DEPTH && !fl) begin
        m_addr = pc;
        nst    = 1;
      end
    end else if (m_st == 1) begin
      if (rdy)      nst = 0;
      else if (fl)  nst = 2;
      else if (tmo) nst = 0;
    end else begin
      if (rdy) nst = 0;
`ifdef FETCH_TIMEOUT_EN
      else if (m_wait == MAXW) nst = 0;
`endif
    end

    if (fl) m_q.delete();
    else begin
      if (m_q.size() != 0 && !st) void'(m_q.pop_front());
      if (done) m_q.push_back({(rdy ? data : 32'h0), m_addr});
    end

    if (fl)       m_fault = 0;
    else if (tmo) m_fault = 1;

    if (nst != m_st)  m_wait = 0;
    else if (m_st != 0) m_wait++;

    if (fl)        pc = redirect;
    else if (done) pc = pc + 32'd4;
    m_st = nst;
  endtask

  int rdy_pct[6] = '{100, 60, 25, 80, 40, 3};
  int fl_pct[6]  = '{0, 5, 10, 2, 20, 4};
  int st_pct[6]  = '{0, 30, 60, 10, 50, 20};

  initial begin
    model_reset();
    redirect = 32'h1900;

    step(1, 0, 0, 0, 0);
    step(1, 0, 0, 0, 0);
    check("rst_imemAddr", imemAddr, 32'h18C0);
    check("rst_imemReq", imemReq, 0);
    check("rst_instrValid", instrValid, 0);
    check("rst_pcHold", pcHold, 1);

    step(0, 0, 0, 0, 0);
    step(0, 0, 0, 0, 0);
    check("first_req", imemReq, 1);
    step(0, 0, 0, 0, 0);
    step(0, 1, 32'h2108000A, 0, 0);
    check("single_pcHold", pcHold, 0);
    step(0, 0, 0, 0, 1);
    check("single_instr", instruction, 32'h2108000A);
    check("single_addr", instrAddress, 32'h18C0);
    check("single_valid", instrValid, 1);
    check("single_hold_after", pcHold, 1);

    repeat (6) step(0, 1, $urandom, 0, 1);
    check("fill_req_idle", imemReq, 0);
    check("fill_pcHold", pcHold, 1);
    check("fill_head0", instrAddress, 32'h18C0);
    step(0, 0, 0, 0, 0);
    check("drain_head0", instrAddress, 32'h18C0);
    step(0, 0, 0, 0, 0);
    check("drain_head1", instrAddress, 32'h18C4);

    for (int k = 0; k < 10 && m_st != 1; k++) step(0, 0, 0, 0, 0);
    check("reach_fetch", m_st, 1);
    redirect = 32'h1900;
    step(0, 0, 0, 1, 0);
    step(0, 0, 0, 0, 0);
    check("flush_drain_req", imemReq, 1);
    check("flush_fifo_empty", instrValid, 0);
    step(0, 1, 32'hDEADBEEF, 0, 0);
    step(0, 0, 0, 0, 0);
    check("drain_no_push", instrValid, 0);
    step(0, 0, 0, 0, 0);
    check("redirect_addr", imemAddr, 32'h1900);
    check("redirect_req", imemReq, 1);

    step(0, 1, 32'h11112222, 0, 1);
    step(0, 0, 0, 0, 1);
    step(0, 1, 32'h33334444, 1, 1);
    check("flush_ready_hold", pcHold, 1);
    step(0, 0, 0, 0, 1);
    check("flush_ready_empty", instrValid, 0);

    repeat (20) step(0, 0, 0, 0, 0);
`ifdef FETCH_TIMEOUT_EN
    check("timeout_fault", fetchFault, 1);
`else
    check("no_timeout_fault", fetchFault, 0);
`endif
    check("long_wait_req", imemReq, 1);
    step(0, 0, 0, 1, 0);
    step(0, 0, 0, 0, 0);
    check("flush_clears_fault", fetchFault, 0);

    for (int p = 0; p < 6; p++) begin
      for (int c = 0; c < 450; c++) begin
        bit rst, rdy, fl, st;
        rst = ($urandom_range(0, 299) == 0);
        rdy = (m_st != 0) && ($urandom_range(0, 99) < rdy_pct[p]);
        fl  = ($urandom_range(0, 99) < fl_pct[p]);
        st  = ($urandom_range(0, 99) < st_pct[p]);
        redirect = $urandom & 32'hFFFF_FFFC;
        step(rst, rdy, $urandom, fl, st);
      end
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
